// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store: round-robin grant,
// response routing back to the issuing requester, and a watchdog while waiting on memory.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_resp_data,
    output logic                    ifu_resp_err,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_resp_data,
    output logic                    lsu_resp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data
);
    localparam int unsigned MW = DATA_WIDTH / 8;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                r_state;
    logic                  r_last_lsu;
    logic                  r_owner_lsu;
    logic [CW-1:0]         r_cnt;
    logic                  r_mem_req_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [MW-1:0]         r_wmask;

    logic                  w_grant_ifu;
    logic                  w_grant_lsu;
    logic                  w_timeout;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_resp_data;

    // On conflict the requester that did not win last time gets the port.
    assign w_grant_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
    assign w_grant_ifu = ifu_req_valid && (!lsu_req_valid || r_last_lsu);

    assign ifu_req_ready = (r_state == IDLE) && w_grant_ifu;
    assign lsu_req_ready = (r_state == IDLE) && w_grant_lsu;

    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT);
    assign w_done      = mem_resp_valid || w_timeout;
    // A real response beats a simultaneous timeout; stores and timeouts return zero data.
    assign w_resp_data = (mem_resp_valid && !r_wen) ? mem_resp_data : '0;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_last_lsu      <= 1'b0;
            r_owner_lsu     <= 1'b0;
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b0;
            r_addr          <= '0;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            ifu_resp_valid  <= 1'b0;
            ifu_resp_data   <= '0;
            ifu_resp_err    <= 1'b0;
            lsu_resp_valid  <= 1'b0;
            lsu_resp_data   <= '0;
            lsu_resp_err    <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
            lsu_resp_err   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_ifu || w_grant_lsu) begin
                        r_owner_lsu     <= w_grant_lsu;
                        r_last_lsu      <= w_grant_lsu;
                        r_addr          <= w_grant_lsu ? lsu_addr : ifu_addr;
                        r_wen           <= w_grant_lsu && lsu_wen;
                        r_wdata         <= w_grant_lsu ? lsu_wdata : '0;
                        r_wmask         <= w_grant_lsu ? lsu_wmask : '0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != TIMEOUT) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_done) begin
                        ifu_resp_valid <= !r_owner_lsu;
                        lsu_resp_valid <= r_owner_lsu;
                        ifu_resp_data  <= r_owner_lsu ? '0 : w_resp_data;
                        lsu_resp_data  <= r_owner_lsu ? w_resp_data : '0;
                        ifu_resp_err   <= !r_owner_lsu && !mem_resp_valid;
                        lsu_resp_err   <= r_owner_lsu && !mem_resp_valid;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queued requester drivers, a behavioural memory and a
// monitor that checks grants and routed responses against expectations pushed at acceptance.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_resp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_resp_data;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_resp_data;
    logic [MW-1:0] mem_wmask;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
        .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          lsu;
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } req_t;
    typedef struct {
        logic          lsu;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    req_t ifu_todo[$];
    req_t lsu_todo[$];
    req_t mem_q[$];
    rsp_t exp_q[$];
    logic grant_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mute     = 1'b0;  // memory accepts requests but never answers
    bit rand_mem = 1'b0;
    int fixed_rdy = -1;
    int stray_req = 0;
    bit hs_ifu = 1'b0, hs_lsu = 1'b0;
    bit busy = 1'b0, last_lsu = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return {a[15:0], ~a[31:16]};
    endfunction

    // Requester drivers: hold valid until accepted, then move on to the next queued request.
    initial begin : drv_ifu
        req_t r;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || hs_ifu) ifu_req_valid = 1'b0;
            if (!rst && !ifu_req_valid && ifu_todo.size() > 0) begin
                r = ifu_todo.pop_front();
                ifu_req_valid = 1'b1;
                ifu_addr      = r.addr;
            end
        end
    end

    initial begin : drv_lsu
        req_t r;
        lsu_req_valid = 1'b0;
        lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || hs_lsu) lsu_req_valid = 1'b0;
            if (!rst && !lsu_req_valid && lsu_todo.size() > 0) begin
                r = lsu_todo.pop_front();
                lsu_req_valid = 1'b1;
                lsu_addr = r.addr; lsu_wen = r.wen; lsu_wdata = r.wdata; lsu_wmask = r.wmask;
            end
        end
    end

    // Behavioural memory: checks the forwarded request, stalls ready, answers after a delay.
    initial begin : memory
        req_t cur;
        bit   in_req = 1'b0, pend = 1'b0;
        int   rcnt = 0, pcnt = 0, stray_done = 0;
        logic [DW-1:0] pdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        cur = '{1'b0, '0, 1'b0, '0, '0};
        forever begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (rst) begin
                in_req = 1'b0; pend = 1'b0; stray_done = stray_req;
                continue;
            end
            if (stray_req != stray_done) begin
                stray_done++;
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hbad0_0bad;
            end
            if (pend) begin
                if (pcnt == 0) begin
                    mem_resp_valid = 1'b1; mem_resp_data = pdata; pend = 1'b0;
                end else pcnt--;
            end
            if (mem_req_valid) begin
                if (!in_req) begin
                    if (mem_q.size() > 0) cur = mem_q.pop_front();
                    else chk("mem_req_unexpected", 64'(mem_req_valid), 64'd0);
                    in_req = 1'b1;
                    rcnt = (fixed_rdy >= 0) ? fixed_rdy : (rand_mem ? $urandom_range(0, 2) : 0);
                end
                chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
                chk("mem_wen_wdata_wmask", 64'({mem_wen, mem_wdata, mem_wmask}),
                    64'({cur.wen, cur.wdata, cur.wmask}));
                if (rcnt == 0) begin
                    mem_req_ready = 1'b1;
                    in_req = 1'b0;
                    if (!mute) begin
                        pend  = 1'b1;
                        pcnt  = rand_mem ? $urandom_range(0, 2) : 0;
                        pdata = memf(cur.addr);
                    end
                end else rcnt--;
            end else if (in_req) begin
                chk("mem_req_valid_held", 64'(mem_req_valid), 64'd1);
                in_req = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every response and checks the grant decision each cycle.
    initial begin : monitor
        rsp_t e;
        req_t q;
        bit   want_ifu, want_lsu;
        forever begin
            @(negedge clk);
            hs_ifu = 1'b0;
            hs_lsu = 1'b0;
            if (rst) begin
                exp_q.delete(); mem_q.delete();
                busy = 1'b0; last_lsu = 1'b0;
                continue;
            end
            if (ifu_resp_valid || lsu_resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_route", 64'({ifu_resp_valid, lsu_resp_valid}),
                        e.lsu ? 64'd1 : 64'd2);
                    chk("resp_data", 64'(e.lsu ? lsu_resp_data : ifu_resp_data), 64'(e.data));
                    chk("resp_err", 64'(e.lsu ? lsu_resp_err : ifu_resp_err), 64'(e.err));
                end
                busy = 1'b0;
            end
            // Port free: a lone requester wins; two requesters take turns.
            want_ifu = 1'b0;
            want_lsu = 1'b0;
            if (!busy) begin
                if (ifu_req_valid && lsu_req_valid) begin
                    want_lsu = !last_lsu;
                    want_ifu = last_lsu;
                end else begin
                    want_ifu = ifu_req_valid;
                    want_lsu = lsu_req_valid;
                end
            end
            chk("req_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'({want_ifu, want_lsu}));
            if (ifu_req_valid && ifu_req_ready) begin
                hs_ifu = 1'b1;
                q = '{1'b0, ifu_addr, 1'b0, '0, '0};
                e = '{1'b0, mute ? '0 : memf(ifu_addr), mute};
            end else if (lsu_req_valid && lsu_req_ready) begin
                hs_lsu = 1'b1;
                q = '{1'b1, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};
                e = '{1'b1, (mute || lsu_wen) ? '0 : memf(lsu_addr), mute};
            end
            if (hs_ifu || hs_lsu) begin
                mem_q.push_back(q);
                exp_q.push_back(e);
                grant_log.push_back(hs_lsu);
                last_lsu = hs_lsu;
                busy     = 1'b1;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int left = budget;
        while (left > 0 && (ifu_todo.size() + lsu_todo.size() + exp_q.size() > 0 ||
                            ifu_req_valid || lsu_req_valid || busy)) begin
            @(negedge clk);
            left--;
        end
        chk("drain_outstanding", 64'(ifu_todo.size() + lsu_todo.size() + exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ctrl"}, 64'({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_resp_err,
                                  lsu_resp_err, mem_wen, mem_wmask}), 64'd0);
        chk({name, "_addr_wdata"}, {mem_addr, mem_wdata}, 64'd0);
        chk({name, "_resp_data"}, {ifu_resp_data, lsu_resp_data}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        req_t r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        #1 rst = 1'b0;

        // Lone fetch: ready at cycle 0, mem request at 1, response at 3.
        @(negedge clk);
        ifu_todo.push_back('{1'b0, 32'h8000_0000, 1'b0, '0, '0});
        @(negedge clk); chk("t1_ifu_ready_c0", 64'(ifu_req_ready), 64'd1);
        @(negedge clk); chk("t1_mem_req_c1", 64'({mem_req_valid, mem_addr}), 64'h1_8000_0000);
        @(negedge clk); chk("t1_no_resp_c2", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        @(negedge clk);
        chk("t1_resp_c3", 64'({ifu_resp_valid, lsu_resp_valid, ifu_resp_data}),
            {32'd0, 2'b10, 32'h0010_0073});
        wait_idle(50);

        // Both requesting: strict alternation starting with lsu.
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            ifu_todo.push_back('{1'b0, 32'h8000_0100 + 32'(i * 4), 1'b0, '0, '0});
            lsu_todo.push_back('{1'b1, 32'h8000_0200 + 32'(i * 4), 1'b0, '0, '0});
        end
        wait_idle(200);
        chk("t2_grant_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("t2_grant_%0d_is_lsu", i), 64'(grant_log[i]), 64'((i % 2) == 0));

        // Store stalled by memory for 5 cycles; memory checks stability each cycle.
        fixed_rdy = 5;
        lsu_todo.push_back('{1'b1, 32'h8000_1000, 1'b1, 32'hdead_beef, 4'b0011});
        wait_idle(100);
        fixed_rdy = -1;

        // Silent memory: error after the counter reaches 4 in WAIT (cycles 2..6), response at 7.
        mute = 1'b1;
        lsu_todo.push_back('{1'b1, 32'h8000_2000, 1'b0, '0, '0});
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 6) chk("t4_no_resp_c6", 64'(lsu_resp_valid), 64'd0);
            if (c == 7)
                chk("t4_err_resp_c7", 64'({lsu_resp_valid, lsu_resp_err, lsu_resp_data}),
                    {30'd0, 2'b11, 32'd0});
        end
        mute = 1'b0;
        stray_req++;
        repeat (4) begin
            @(negedge clk);
            chk("t4_stray_dropped", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        end
        wait_idle(50);

        // Reset while waiting on memory drops the transaction.
        mute = 1'b1;
        ifu_todo.push_back('{1'b0, 32'h8000_3000, 1'b0, '0, '0});
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("t5_async");
        chk("t5_ready_low", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        mute = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_resp_after_reset", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        end
        ifu_todo.push_back('{1'b0, 32'h8000_0040, 1'b0, '0, '0});
        wait_idle(50);

        // Random traffic with random memory stalls and latencies.
        rand_mem = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0 && ifu_todo.size() < 2) begin
                r = '{1'b0, $urandom & 32'hffff_fffc, 1'b0, '0, '0};
                ifu_todo.push_back(r);
            end
            if ($urandom_range(0, 3) == 0 && lsu_todo.size() < 2) begin
                r = '{1'b1, $urandom, 1'($urandom), $urandom, 4'($urandom)};
                lsu_todo.push_back(r);
            end
        end
        wait_idle(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
